// File: rtl/nn_uart_pkg.sv
// Shared framing definitions for the UART image receiver and the matching result framer.
package nn_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         IMAGE_BYTES_DEF = 784;
  // Frame: SYNC, LEN_HI, LEN_LO, payload, CHK (XOR of payload)
  localparam int         LEN_W           = 16;
  localparam logic [7:0] CHK_INIT        = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAYLOAD,
    ST_CHECK,
    ST_READY
  } frame_state_e;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: reloads on clear or while disabled, counts down, and expires at zero.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // Reset value of zero is safe: every entry into an enabled state passes a disabled cycle that reloads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (!en || clr)
      cnt_q <= LOAD;
    else if (cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign expire = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/image_frame_receiver.sv
// Frames UART bytes into neuron RAM writes and releases the accelerator only on a verified image.
//
// state      | meaning
// IDLE       | hunting for the sync byte
// LEN_HI     | waiting for the high length byte
// LEN_LO     | waiting for the low length byte, length checked here
// PAYLOAD    | writing payload bytes to RAM, accumulating XOR
// CHECK      | waiting for the checksum byte
// READY      | verified image held in RAM until consume
module image_frame_receiver
  import nn_uart_pkg::*;
#(
  parameter int         IMAGE_BYTES    = IMAGE_BYTES_DEF,
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              consume,
  output logic [ADDR_W-1:0] ram_wr_adr,
  output logic [7:0]        ram_wr_data,
  output logic              ram_wr_en,
  output logic              image_ready,
  output logic              err_length,
  output logic              err_checksum,
  output logic              err_timeout,
  output logic [7:0]        err_count
);

  frame_state_e      state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        xor_q;
  logic              wr_d, err_len_d, err_chk_d, err_to_d;
  logic              tmo_en, tmo_expire;

  assign tmo_en = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                  (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

  frame_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tmo_en),
    .clr     (rx_done),
    .expire  (tmo_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = 1'b0;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_to_d  = 1'b0;
    case (state_q)
      ST_IDLE:    if (rx_done && rx_data == SYNC_BYTE) state_d = ST_LEN_HI;
      ST_LEN_HI:  if (rx_done) state_d = ST_LEN_LO;
      ST_LEN_LO:
        if (rx_done) begin
          if ({len_hi_q, rx_data} == LEN_W'(IMAGE_BYTES)) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d   = ST_IDLE;
            err_len_d = 1'b1;
          end
        end
      ST_PAYLOAD:
        if (rx_done) begin
          wr_d = 1'b1;
          if (idx_q == ADDR_W'(IMAGE_BYTES - 1)) state_d = ST_CHECK;
        end
      ST_CHECK:
        if (rx_done) begin
          if (rx_data == xor_q) begin
            state_d = ST_READY;
          end else begin
            state_d   = ST_IDLE;
            err_chk_d = 1'b1;
          end
        end
      ST_READY:   if (consume) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Expiry is already masked by rx_done inside the counter, so a byte in the same cycle wins
    if (tmo_expire) begin
      state_d  = ST_IDLE;
      err_to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_hi_q     <= 8'h00;
      idx_q        <= '0;
      xor_q        <= CHK_INIT;
      ram_wr_en    <= 1'b0;
      ram_wr_adr   <= '0;
      ram_wr_data  <= 8'h00;
      image_ready  <= 1'b0;
      err_length   <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_count    <= 8'h00;
    end else begin
      if (state_q == ST_LEN_HI && rx_done) len_hi_q <= rx_data;
      if (state_q == ST_LEN_LO) begin
        idx_q <= '0;
        xor_q <= CHK_INIT;
      end else if (wr_d) begin
        idx_q <= idx_q + 1'b1;
        xor_q <= xor_q ^ rx_data;
      end
      ram_wr_en <= wr_d;
      if (wr_d) begin
        ram_wr_adr  <= idx_q;
        ram_wr_data <= rx_data;
      end
      image_ready  <= (state_d == ST_READY);
      err_length   <= err_len_d;
      err_checksum <= err_chk_d;
      err_timeout  <= err_to_d;
      if ((err_len_d || err_chk_d || err_to_d) && err_count != 8'hFF)
        err_count <= err_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_image_frame_receiver.sv
// Randomized bench for image_frame_receiver with a frame-position reference model checked every cycle.
module tb_image_frame_receiver;
  import nn_uart_pkg::*;

  localparam int N  = 784;
  localparam int AW = 10;
  localparam int T  = 20000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic          consume = 1'b0;
  logic [AW-1:0] ram_wr_adr;
  logic [7:0]    ram_wr_data;
  logic          ram_wr_en;
  logic          image_ready;
  logic          err_length;
  logic          err_checksum;
  logic          err_timeout;
  logic [7:0]    err_count;

  image_frame_receiver #(
    .IMAGE_BYTES(N), .ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done), .consume(consume),
    .ram_wr_adr(ram_wr_adr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .image_ready(image_ready), .err_length(err_length), .err_checksum(err_checksum),
    .err_timeout(err_timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "got" is how many bytes of the current frame have been accepted
  int            got = 0;
  bit            rdy = 0;
  int            idle = 0;
  logic [15:0]   mlen = '0;
  logic [7:0]    mxor = '0;
  bit            e_wr = 0, e_rdy = 0, e_el = 0, e_ec = 0, e_et = 0;
  logic [AW-1:0] e_adr = '0;
  logic [7:0]    e_data = '0;
  int            e_cnt = 0;
  int            m_writes = 0;
  int            d_writes = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      got = 0; rdy = 0; idle = 0; mlen = '0; mxor = '0;
      e_wr = 0; e_rdy = 0; e_el = 0; e_ec = 0; e_et = 0; e_cnt = 0;
      e_adr = '0; e_data = '0;
    end else begin
      e_wr = 0; e_el = 0; e_ec = 0; e_et = 0;
      if (rdy) begin
        if (consume) rdy = 0;
      end else if (got == 0) begin
        if (rx_done && rx_data == 8'hA5) begin got = 1; idle = 0; end
      end else if (rx_done) begin
        idle = 0;
        if (got == 1) begin
          mlen[15:8] = rx_data; got = 2;
        end else if (got == 2) begin
          mlen[7:0] = rx_data;
          if (mlen == 16'(N)) begin got = 3; mxor = 8'h00; end
          else begin got = 0; e_el = 1; end
        end else if (got < 3 + N) begin
          e_wr = 1; e_adr = AW'(got - 3); e_data = rx_data;
          mxor = mxor ^ rx_data; got++; m_writes++;
        end else begin
          if (rx_data == mxor) rdy = 1; else e_ec = 1;
          got = 0;
        end
      end else if (idle == T) begin
        got = 0; e_et = 1;
      end else begin
        idle++;
      end
      if ((e_el || e_ec || e_et) && e_cnt < 255) e_cnt++;
      e_rdy = rdy;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      n_tests++;
      if (ram_wr_en) d_writes++;
      if (ram_wr_en !== e_wr || (e_wr && (ram_wr_adr !== e_adr || ram_wr_data !== e_data)) ||
          image_ready !== e_rdy || err_length !== e_el || err_checksum !== e_ec ||
          err_timeout !== e_et || err_count !== 8'(e_cnt)) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL cycle_compare t=%0t actual wr=%b adr=%0d dat=%h rdy=%b el=%b ec=%b et=%b cnt=%0d required wr=%b adr=%0d dat=%h rdy=%b el=%b ec=%b et=%b cnt=%0d",
                   $time, ram_wr_en, ram_wr_adr, ram_wr_data, image_ready, err_length, err_checksum,
                   err_timeout, err_count, e_wr, e_adr, e_data, e_rdy, e_el, e_ec, e_et, e_cnt);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  logic [7:0] img [N];

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) img[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic pulse_consume();
    consume = 1'b1;
    @(negedge clk);
    consume = 1'b0;
  endtask

  // Sends SYNC, length, the first nbytes of img and, for a complete payload, the checksum
  task automatic send_frame(input int len, input int nbytes, input bit bad_chk, input int maxgap);
    logic [7:0]  x;
    logic [15:0] l;
    x = 8'h00;
    l = 16'(len);
    send_byte(8'hA5, $urandom_range(0, maxgap));
    send_byte(l[15:8], $urandom_range(0, maxgap));
    send_byte(l[7:0], $urandom_range(0, maxgap));
    for (int i = 0; i < nbytes; i++) begin
      send_byte(img[i], $urandom_range(0, maxgap));
      x = x ^ img[i];
    end
    if (nbytes == N) send_byte(x ^ {7'd0, bad_chk}, $urandom_range(0, maxgap));
  endtask

  int outs_zero;

  initial begin
    #1 reset_n = 1'b0;
    #1;
    outs_zero = int'({ram_wr_en, ram_wr_adr, ram_wr_data, image_ready, err_length,
                      err_checksum, err_timeout, err_count} == '0);
    chk("reset_outputs_zero", outs_zero, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Good pattern frame, back-to-back bytes
    fill_pattern();
    send_frame(N, N, 1'b0, 0);
    idle_cycles(3);
    chk("good_writes", d_writes, 784);
    chk("model_writes", m_writes, 784);
    chk("good_ready", int'(image_ready), 1);
    chk("good_err_count", int'(err_count), 0);

    // Bytes while READY are dropped; consume with A5 must not start a frame
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), $urandom_range(0, 2));
    chk("ready_drop_writes", d_writes, 784);
    chk("ready_hold", int'(image_ready), 1);
    consume = 1'b1; rx_done = 1'b1; rx_data = 8'hA5;
    @(negedge clk);
    consume = 1'b0; rx_done = 1'b0;
    send_byte(8'h03, 0);
    send_byte(8'h10, 0);
    for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i), 0);
    idle_cycles(2);
    chk("consume_a5_writes", d_writes, 784);
    chk("consume_released", int'(image_ready), 0);

    // Length mismatch, then a good random frame
    fill_random();
    send_frame(783, 0, 1'b0, 1);
    idle_cycles(2);
    chk("len_err_count", int'(err_count), 1);
    chk("len_no_writes", d_writes, 784);
    send_frame(N, N, 1'b0, 2);
    idle_cycles(2);
    chk("after_len_ready", int'(image_ready), 1);
    chk("after_len_writes", d_writes, 1568);
    pulse_consume();
    idle_cycles(2);

    // Wrong checksum
    fill_random();
    send_frame(N, N, 1'b1, 1);
    idle_cycles(2);
    chk("chk_err_count", int'(err_count), 2);
    chk("chk_not_ready", int'(image_ready), 0);
    chk("chk_writes", d_writes, 2352);

    // Timeout after payload byte 100, then a full resend
    send_frame(N, 101, 1'b0, 0);
    idle_cycles(T + 5);
    chk("timeout_err_count", int'(err_count), 3);
    chk("timeout_writes", d_writes, 2453);
    send_frame(N, N, 1'b0, 1);
    idle_cycles(2);
    chk("timeout_resend_ready", int'(image_ready), 1);
    pulse_consume();
    idle_cycles(2);

    // Reset mid-payload
    fill_random();
    send_frame(N, 400, 1'b0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    outs_zero = int'({ram_wr_en, ram_wr_adr, ram_wr_data, image_ready, err_length,
                      err_checksum, err_timeout, err_count} == '0);
    chk("midframe_reset_zero", outs_zero, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    send_frame(N, N, 1'b0, 1);
    idle_cycles(2);
    chk("post_reset_ready", int'(image_ready), 1);
    chk("post_reset_err_count", int'(err_count), 0);
    pulse_consume();
    idle_cycles(2);

    // Random frames with random gaps and random checksum corruption
    for (int f = 0; f < 3; f++) begin
      bit bad;
      bad = 1'($urandom_range(0, 1));
      fill_random();
      send_frame(N, N, bad, 2);
      idle_cycles(2);
      chk("rand_ready", int'(image_ready), int'(!bad));
      pulse_consume();
      idle_cycles(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/image_frame_receiver.md
# image_frame_receiver

Framing stage between the UART byte receiver and the neural accelerator's neuron RAM write port. It hunts for a sync byte, checks the frame length, and writes IMAGE_BYTES payload bytes to consecutive RAM addresses. It verifies an XOR checksum, then holds `image_ready` until the result path reports the frame consumed. Bad frames never raise `image_ready`. The accelerator therefore only starts on a complete, verified image.

## Interface
- `IMAGE_BYTES`, 784: required payload length, in bytes.
- `ADDR_W`, 10: RAM address width. Must satisfy 2^ADDR_W ≥ IMAGE_BYTES.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 20000: maximum idle clocks between bytes inside a frame.
- `clk` in 1: single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from UART_RX. Valid only while `rx_done` is high.
- `rx_done` in 1: one-cycle strobe, one per received byte.
- `consume` in 1: one-cycle pulse from the result/TX controller meaning "results sent, image may be overwritten".
- `ram_wr_adr` out ADDR_W: payload write address.
- `ram_wr_data` out 8: payload write data.
- `ram_wr_en` out 1: one-cycle write strobe.
- `image_ready` out 1: level signal; a verified image is in RAM. Drives the accelerator reset release (accelerator reset = ~image_ready).
- `err_length` out 1: one-cycle pulse on a length mismatch.
- `err_checksum` out 1: one-cycle pulse on a checksum mismatch.
- `err_timeout` out 1: one-cycle pulse on an inter-byte timeout.
- `err_count` out 8: saturating count of all errors.

## Operation
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, payload[0..LEN-1], CHK. CHK = XOR of all payload bytes.
- States and transitions:
  - IDLE:
    - `rx_done` with SYNC_BYTE → LEN_HI.
    - Any other byte is discarded; stay in IDLE.
  - LEN_HI: latch the byte as the high length byte → LEN_LO.
  - LEN_LO:
    - If {hi,lo} == IMAGE_BYTES → PAYLOAD, with the byte index and running XOR both cleared.
    - Otherwise pulse `err_length` → IDLE.
  - PAYLOAD:
    - Each `rx_done` writes `rx_data` to address = index, XORs it into the running checksum, and increments the index.
    - The byte with index IMAGE_BYTES-1 → CHECK.
  - CHECK:
    - Next `rx_done` with byte == running XOR → READY.
    - Any other byte: pulse `err_checksum` → IDLE.
  - READY:
    - `image_ready`=1. All `rx_done` bytes are dropped.
    - `consume` → IDLE.
- Timeout:
  - The counter runs only in LEN_HI, LEN_LO, PAYLOAD and CHECK, and clears on every `rx_done`.
  - When it reaches TIMEOUT_CYCLES: pulse `err_timeout` → IDLE.
- `err_count` increments on each error pulse and saturates at 255.
- RAM contents after an aborted frame are undefined. `image_ready` is never raised for that frame.

## Timing
- Reset values: state IDLE, every output 0, all counters 0.
- `reset_n` assertion mid-frame aborts immediately. No error pulse, and `err_count` clears.
- Write latency:
  - `ram_wr_en`, `ram_wr_adr` and `ram_wr_data` are registered and appear 1 cycle after the `rx_done` that carried the byte.
  - `ram_wr_en` is high for exactly one cycle.
- `image_ready` rises 1 cycle after the `rx_done` of a matching CHK byte.
- `image_ready` falls 1 cycle after `consume`.
- `consume` outside READY is ignored.
- `consume` and `rx_done` in the same cycle while in READY: the byte is dropped and the state goes to IDLE. That byte is never taken as SYNC.
- A timeout and an `rx_done` in the same cycle: `rx_done` wins, the byte is processed normally, and the counter clears.
- Error pulses are registered and appear 1 cycle after the triggering event.
- Back-to-back `rx_done` on consecutive cycles must be accepted with no loss (UART_RX never does this, but the bench does).

## Structure
- Shared package `nn_uart_pkg` holds:
  - the state enum;
  - SYNC_BYTE;
  - default IMAGE_BYTES;
  - the frame-format constants, so a matching result framer can reuse them.
- One natural sub-module: `frame_timeout_counter`, holding the clear/enable/expire logic sized by $clog2(TIMEOUT_CYCLES+1).
- All other logic (FSM, index, XOR, write register) stays in this block.

## Test plan
- Good frame, IMAGE_BYTES=784, payload[i]=i[7:0], correct CHK:
  - Expect 784 single-cycle writes with address i and data i[7:0].
  - Expect `image_ready`=1 one cycle after CHK.
  - Expect no error pulses.
- Length mismatch, LEN=783:
  - Expect `err_length` pulse, no writes, `err_count`=1, state IDLE.
  - A following good frame must then succeed.
- Wrong CHK (XOR ^ 8'h01):
  - Expect all 784 writes, `err_checksum` pulse, `image_ready` stays 0.
- Timeout: stop after payload byte 100 and wait TIMEOUT_CYCLES:
  - Expect `err_timeout` pulse.
  - Resending the full frame gives `image_ready`=1.
- READY behaviour:
  - Bytes sent while READY cause no writes.
  - `consume` coincident with `rx_done` of A5, then LEN bytes: that A5 is dropped and no frame starts.
- Reset: pull `reset_n` low at payload byte 400.
  - Expect every output 0 immediately.
  - A later full frame completes normally.
